// File: rtl/systolic_skew_feeder_pkg.sv
// Shared defaults, state encoding and run-length helper for the systolic operand feeder.
package systolic_pkg;

  localparam int N_DEF  = 4;
  localparam int DW_DEF = 16;

  typedef enum logic [2:0] {IDLE, CLR, STREAM, DRAIN, DONE} feeder_state_e;

  function automatic int stream_len(input int n);
    return 3 * n - 2;
  endfunction

  localparam int STREAM_LEN = stream_len(N_DEF);

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Host load channel: one matrix row per ld_valid && ld_ready handshake.
interface systolic_skew_feeder_if
  import systolic_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF
) ();

  logic                 ld_valid;
  logic                 ld_ready;
  logic                 ld_sel;
  logic [$clog2(N)-1:0] ld_idx;
  logic [N*DW-1:0]      ld_data;

  modport master (output ld_valid, ld_sel, ld_idx, ld_data, input ld_ready);
  modport slave  (input ld_valid, ld_sel, ld_idx, ld_data, output ld_ready);

endinterface

// File: rtl/systolic_skew_feeder_skew_lane.sv
// One skew lane: presents element (t - LANE) of its row/column, or 0 outside the wavefront.
module skew_lane
  import systolic_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int DW   = DW_DEF,
  parameter int TW   = $clog2(3 * N_DEF) + 1,
  parameter int LANE = 0
) (
  input  logic [TW-1:0]   i_t,
  input  logic [N*DW-1:0] i_elems,
  output logic [DW-1:0]   o_val
);

  logic [TW:0] w_k;

  // t < LANE wraps to a large value, so it never matches an element index
  assign w_k = {1'b0, i_t} - (TW+1)'(LANE);

  always_comb begin
    o_val = '0;
    for (int k = 0; k < N; k++) begin
      if (w_k == (TW+1)'(k)) o_val = i_elems[k*DW +: DW];
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Buffers A/B and streams skewed wavefronts into the PE grid; FEEDER_STALL_EN adds stall.
// state  | meaning
// IDLE   | accepting row loads, waiting for start
// CLR    | one-cycle accumulator clear
// STREAM | t = 0..3N-3 wavefront slots on a_feed/b_feed
// DRAIN  | zero feeds, PEs still enabled for the last product
// DONE   | one-cycle completion pulse
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  systolic_skew_feeder_if.slave ld_if,
  input  logic                  i_start,
  input  logic                  i_stall,
  output logic [N*DW-1:0]       o_a_feed,
  output logic [N*DW-1:0]       o_b_feed,
  output logic                  o_feed_valid,
  output logic                  o_pe_en,
  output logic                  o_pe_clr,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int TW = $clog2(3 * N) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(stream_len(N) - 1);

  feeder_state_e   r_state, w_state_nxt;
  logic [TW-1:0]   r_t, w_t_nxt;
  logic            w_freeze;

  logic [N*DW-1:0] r_a_buf [N];
  logic [N*DW-1:0] r_b_buf [N];
  logic [N*DW-1:0] w_b_col [N];
  logic [N*DW-1:0] w_a_lane, w_b_lane;

  logic [N*DW-1:0] r_a_feed, r_b_feed, w_a_nxt, w_b_nxt;
  logic            r_feed_valid, r_pe_en, r_pe_clr, r_busy, r_done, r_ld_ready;
  logic            w_fv_nxt, w_pe_en_nxt;

  always_comb begin : p_next
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    w_freeze    = 1'b0;
`ifdef FEEDER_STALL_EN
    w_freeze    = i_stall && ((r_state == STREAM) || (r_state == DRAIN));
`endif
    case (r_state)
      IDLE:    if (i_start && !ld_if.ld_valid) w_state_nxt = CLR;
      CLR: begin
        w_state_nxt = STREAM;
        w_t_nxt     = '0;
      end
      STREAM: begin
        if (!w_freeze) begin
          if (r_t == T_LAST) w_state_nxt = DRAIN;
          else               w_t_nxt     = r_t + 1'b1;
        end
      end
      DRAIN:   if (!w_freeze) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

`ifndef FEEDER_STALL_EN
  logic w_unused_stall;
  assign w_unused_stall = i_stall;
`endif

  always_comb begin
    for (int j = 0; j < N; j++) begin
      for (int k = 0; k < N; k++) begin
        w_b_col[j][k*DW +: DW] = r_b_buf[k][j*DW +: DW];
      end
    end
  end

  // lanes look at the next t so the feed registers line up with the state register
  for (genvar g = 0; g < N; g++) begin : g_lane
    skew_lane #(.N(N), .DW(DW), .TW(TW), .LANE(g)) u_a_lane (
      .i_t     (w_t_nxt),
      .i_elems (r_a_buf[g]),
      .o_val   (w_a_lane[g*DW +: DW])
    );
    skew_lane #(.N(N), .DW(DW), .TW(TW), .LANE(g)) u_b_lane (
      .i_t     (w_t_nxt),
      .i_elems (w_b_col[g]),
      .o_val   (w_b_lane[g*DW +: DW])
    );
  end

  always_comb begin : p_out
    w_fv_nxt    = (w_state_nxt == STREAM);
    w_a_nxt     = w_fv_nxt ? w_a_lane : '0;
    w_b_nxt     = w_fv_nxt ? w_b_lane : '0;
    w_pe_en_nxt = (w_state_nxt == CLR) || (w_state_nxt == STREAM) || (w_state_nxt == DRAIN);
    if (w_freeze) begin
      w_fv_nxt    = r_feed_valid;
      w_a_nxt     = r_a_feed;
      w_b_nxt     = r_b_feed;
      w_pe_en_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_t          <= '0;
      r_a_feed     <= '0;
      r_b_feed     <= '0;
      r_feed_valid <= 1'b0;
      r_pe_en      <= 1'b0;
      r_pe_clr     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_ld_ready   <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_t          <= w_t_nxt;
      r_a_feed     <= w_a_nxt;
      r_b_feed     <= w_b_nxt;
      r_feed_valid <= w_fv_nxt;
      r_pe_en      <= w_pe_en_nxt;
      r_pe_clr     <= (w_state_nxt == CLR);
      r_busy       <= (w_state_nxt != IDLE);
      r_done       <= (w_state_nxt == DONE);
      r_ld_ready   <= (w_state_nxt == IDLE);
    end
  end

  // operand buffers are deliberately left out of reset
  always_ff @(posedge clk) begin
    if (!rst && ld_if.ld_valid && r_ld_ready) begin
      if (ld_if.ld_sel) r_b_buf[ld_if.ld_idx] <= ld_if.ld_data;
      else              r_a_buf[ld_if.ld_idx] <= ld_if.ld_data;
    end
  end

  assign ld_if.ld_ready = r_ld_ready;
  assign o_a_feed       = r_a_feed;
  assign o_b_feed       = r_b_feed;
  assign o_feed_valid   = r_feed_valid;
  assign o_pe_en        = r_pe_en;
  assign o_pe_clr       = r_pe_clr;
  assign o_busy         = r_busy;
  assign o_done         = r_done;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder; stall expectations follow FEEDER_STALL_EN.
module tb_systolic_skew_feeder;
  import systolic_pkg::*;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int W  = N * DW;
`ifdef FEEDER_STALL_EN
  localparam int STALL_EXTRA = 3;
`else
  localparam int STALL_EXTRA = 0;
`endif
  // hand-derived slot tables for A = I, B = 1..16
  localparam int DIR_B0 [STREAM_LEN] = '{1, 5, 9, 13, 0, 0, 0, 0, 0, 0};
  localparam int DIR_B3 [STREAM_LEN] = '{0, 0, 0, 4, 8, 12, 16, 0, 0, 0};
  localparam int DIR_A2 [STREAM_LEN] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         pe_en;
  } feed_t;

  logic clk = 1'b0;
  logic rst, i_start, i_stall;
  logic [W-1:0] o_a_feed, o_b_feed;
  logic o_feed_valid, o_pe_en, o_pe_clr, o_busy, o_done;

  systolic_skew_feeder_if #(.N(N), .DW(DW)) ld_if ();

  systolic_skew_feeder #(.N(N), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ld_if        (ld_if),
    .i_start      (i_start),
    .i_stall      (i_stall),
    .o_a_feed     (o_a_feed),
    .o_b_feed     (o_b_feed),
    .o_feed_valid (o_feed_valid),
    .o_pe_en      (o_pe_en),
    .o_pe_clr     (o_pe_clr),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  feed_t        exp_feed_q [$];
  int           exp_clr_q  [$];
  int           exp_done_q [$];
  logic [W-1:0] hist_a [$];
  logic [W-1:0] hist_b [$];
  int           mA [N][N];
  int           mB [N][N];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  bit           prev_done = 1'b0;
  bit           rec_hist = 1'b0;
  feed_t        mon_e;
  int           mon_c;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: DUT event with no expectation queued (cycle %0d)", name, cyc);
  endtask

  function automatic logic [W-1:0] mdl_a(input int t);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < N) v[i*DW +: DW] = DW'(mA[i][t-i]);
    return v;
  endfunction

  function automatic logic [W-1:0] mdl_b(input int t);
    logic [W-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < N) v[j*DW +: DW] = DW'(mB[t-j][j]);
    return v;
  endfunction

  // monitor: pops expectations whenever the DUT presents a feed slot, clear or done
  always @(negedge clk) begin
    if (prev_done) check("busy_after_done", o_busy, 0);
    prev_done = o_done;
    if (o_feed_valid) begin
      if (exp_feed_q.size() == 0) unexpected("feed_slot");
      else begin
        mon_e = exp_feed_q.pop_front();
        check("a_feed", o_a_feed, mon_e.a);
        check("b_feed", o_b_feed, mon_e.b);
        check("pe_en_stream", o_pe_en, mon_e.pe_en);
        if (rec_hist && o_pe_en) begin
          hist_a.push_back(o_a_feed);
          hist_b.push_back(o_b_feed);
        end
      end
    end else if (o_busy) begin
      check("feed_zero_when_invalid", o_a_feed | o_b_feed, 0);
    end
    if (o_pe_clr) begin
      if (exp_clr_q.size() == 0) unexpected("pe_clr");
      else begin
        mon_c = exp_clr_q.pop_front();
        check("pe_clr_cycle", cyc, mon_c);
      end
    end
    if (o_done) begin
      if (exp_done_q.size() == 0) unexpected("done");
      else begin
        mon_c = exp_done_q.pop_front();
        check("done_cycle", cyc, mon_c);
        check("done_pe_en", o_pe_en, 0);
        check("done_busy", o_busy, 1);
      end
    end
  end

  task automatic load(input bit sel, input int idx, input int e0, input int e1,
                      input int e2, input int e3, input bit with_start);
    int e [N];
    logic [W-1:0] d;
    e = '{e0, e1, e2, e3};
    for (int k = 0; k < N; k++) d[k*DW +: DW] = DW'(e[k]);
    ld_if.ld_valid = 1'b1;
    ld_if.ld_sel   = sel;
    ld_if.ld_idx   = 2'(idx);
    ld_if.ld_data  = d;
    i_start        = with_start;
    @(posedge clk); #1;
    ld_if.ld_valid = 1'b0;
    i_start        = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (sel) mB[idx][k] = e[k];
      else     mA[idx][k] = e[k];
    end
  endtask

  task automatic run(input bit intrude, input bit do_stall, input bit do_rst);
    int c0;
    feed_t e;
    c0 = cyc;
    exp_clr_q.push_back(c0 + 1);
    for (int t = 0; t < STREAM_LEN; t++) begin
      e.a = mdl_a(t); e.b = mdl_b(t); e.pe_en = 1'b1;
      exp_feed_q.push_back(e);
      if (do_stall && t == 4) begin
        e.pe_en = 1'b0;
        for (int k = 0; k < STALL_EXTRA; k++) exp_feed_q.push_back(e);
      end
    end
    exp_done_q.push_back(c0 + 1 + 3 * N + (do_stall ? STALL_EXTRA : 0));
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int s = 0; s < 3 * N + 8; s++) begin
      if (s == 0) begin
        check("clr_pe_en", o_pe_en, 1);
        check("clr_busy", o_busy, 1);
        check("clr_ld_ready", ld_if.ld_ready, 0);
      end
      if (intrude && s == 4) begin
        i_start        = 1'b1;
        ld_if.ld_valid = 1'b1;
        ld_if.ld_sel   = 1'b0;
        ld_if.ld_idx   = 2'd0;
        ld_if.ld_data  = 64'hDEAD_BEEF_CAFE_F00D;
      end
      if (intrude && s == 5) check("stream_ld_ready", ld_if.ld_ready, 0);
      if (intrude && s == 6) begin
        i_start        = 1'b0;
        ld_if.ld_valid = 1'b0;
      end
      if (do_stall && s == 5) i_stall = 1'b1;
      if (do_stall && s == 8) i_stall = 1'b0;
      if (do_rst && s == 6) rst = 1'b1;
      if (do_rst && s == 7) begin
        rst = 1'b0;
        check("rst_run_feeds", o_a_feed | o_b_feed, 0);
        check("rst_run_fv", o_feed_valid, 0);
        check("rst_run_pe_en", o_pe_en, 0);
        check("rst_run_busy", o_busy, 0);
        check("rst_run_done", o_done, 0);
        check("rst_run_ld_ready", ld_if.ld_ready, 1);
        exp_feed_q.delete();
        exp_done_q.delete();
      end
      @(posedge clk); #1;
    end
    check("feed_q_drained", exp_feed_q.size(), 0);
    check("done_q_drained", exp_done_q.size(), 0);
    check("clr_q_drained", exp_clr_q.size(), 0);
  endtask

  task automatic check_product_and_tables();
    logic [W-1:0] va, vb;
    int acc, ta, tb, hl;
    hl = hist_a.size();
    check("hist_len", hl, STREAM_LEN);
    if (hl == STREAM_LEN) begin
      for (int t = 0; t < STREAM_LEN; t++) begin
        va = hist_a[t];
        vb = hist_b[t];
        check("dir_b_col0", vb[0 +: DW], DIR_B0[t]);
        check("dir_b_col3", vb[3*DW +: DW], DIR_B3[t]);
        check("dir_a_row2", va[2*DW +: DW], DIR_A2[t]);
      end
      // output-stationary grid: PE(i,j) meets a-slot s-j of row i and b-slot s-i of column j
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          acc = 0;
          for (int s = 0; s < hl + 2 * N; s++) begin
            ta = s - j;
            tb = s - i;
            if (ta >= 0 && ta < hl && tb >= 0 && tb < hl) begin
              va = hist_a[ta];
              vb = hist_b[tb];
              acc += int'(va[i*DW +: DW]) * int'(vb[j*DW +: DW]);
            end
          end
          check("c_equals_b", acc, mB[i][j]);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst            = 1'b1;
    i_start        = 1'b0;
    i_stall        = 1'b0;
    ld_if.ld_valid = 1'b0;
    ld_if.ld_sel   = 1'b0;
    ld_if.ld_idx   = '0;
    ld_if.ld_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_ld_ready", ld_if.ld_ready, 1);
    check("reset_busy", o_busy, 0);
    check("reset_done", o_done, 0);
    check("reset_fv", o_feed_valid, 0);
    check("reset_pe_en", o_pe_en, 0);
    check("reset_pe_clr", o_pe_clr, 0);
    check("reset_feeds", o_a_feed | o_b_feed, 0);

    load(0, 0, 1, 0, 0, 0, 0);
    load(0, 1, 0, 1, 0, 0, 0);
    load(0, 2, 0, 0, 1, 0, 0);
    load(0, 3, 0, 0, 0, 1, 0);
    load(1, 0, 1, 2, 3, 4, 0);
    load(1, 1, 5, 6, 7, 8, 0);
    load(1, 2, 9, 10, 11, 12, 0);
    load(1, 3, 13, 14, 15, 16, 0);

    rec_hist = 1'b1;
    run(0, 0, 0);
    rec_hist = 1'b0;
    check_product_and_tables();

    // load and start together: load wins, no run begins
    load(1, 3, 17, 18, 19, 20, 1);
    check("sim_ld_busy", o_busy, 0);
    check("sim_ld_ready", ld_if.ld_ready, 1);
    check("sim_ld_pe_clr", o_pe_clr, 0);

    run(1, 0, 0);
    run(0, 0, 1);
    run(0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
